// File: rtl/core_hazard_ctrl_if.sv
// Data-peripheral request/response bundle between the hazard controller and the bus.
// The controller is the master; the peripheral fabric is the slave.
interface core_hazard_ctrl_if #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned NUM_REGIONS = 2
);
  localparam int unsigned RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [RW-1:0]     d_region;
  logic              d_ready;

  modport master (output d_valid, d_addr, d_region, input d_ready);
  modport slave  (input d_valid, d_addr, d_region, output d_ready);
endinterface

// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and mul/div stalls plus a timed
// valid/ready arbiter for accesses into N peripheral address windows.
module core_hazard_ctrl #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned NUM_REGIONS    = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {64'h3000_0000, 64'h2000_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {64'h4000_0000, 64'h3000_0000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        IF_rs,
  input  logic [4:0]        IF_rt,
  input  logic              IF_B_is_reg,
  input  logic [4:0]        ID_W_regnum,
  input  logic              ID_mem_read,
  input  logic              md_busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic              EX_mem_read,
  input  logic              EX_mem_write,
  core_hazard_ctrl_if.master bus,
  output logic              bus_err,
  output logic              stall,
  output logic [31:0]       stall_cnt
);
  localparam int unsigned RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]     region_q, region_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [NUM_REGIONS-1:0] hit;
  logic [RW-1:0]          idx_chain [NUM_REGIONS+1];
  logic                   access;
  logic                   load_use;
  logic                   valid_c;
  logic [ADDR_W-1:0]      d_addr_c;
  logic [RW-1:0]          region_c;
  logic                   bus_err_c;
  logic                   d_valid;

  // Window decode; the chain resolves overlaps in favour of the lowest index.
  assign idx_chain[NUM_REGIONS] = '0;
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_hit
    assign hit[g] = (addr >= REGION_BASE[g*ADDR_W +: ADDR_W]) &&
                    (addr <  REGION_LIMIT[g*ADDR_W +: ADDR_W]);
    assign idx_chain[g] = hit[g] ? RW'(g) : idx_chain[g+1];
  end

  assign access   = (EX_mem_read | EX_mem_write) & (|hit);
  assign load_use = ID_mem_read && (ID_W_regnum != 5'd0) &&
                    ((IF_rs == ID_W_regnum) || (IF_B_is_reg && (IF_rt == ID_W_regnum)));

  // Next-state and request decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    region_d  = region_q;
    valid_c   = 1'b0;
    d_addr_c  = '0;
    region_c  = '0;
    bus_err_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_c  = access;
        d_addr_c = addr;
        region_c = idx_chain[0];
        if (access && !bus.d_ready) begin
          addr_d   = addr;
          region_d = idx_chain[0];
          cnt_d    = CW'(1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        valid_c  = 1'b1;
        d_addr_c = addr_q;
        region_c = region_q;
        if (bus.d_ready) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERR: begin
        bus_err_c = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the request immediately so a dropped WAIT never leaks out.
  assign d_valid      = rst_n & valid_c;
  assign bus.d_valid  = d_valid;
  assign bus.d_addr   = rst_n ? d_addr_c : '0;
  assign bus.d_region = rst_n ? region_c : '0;
  assign bus_err      = rst_n & bus_err_c;

  assign stall       = load_use | md_busy | (d_valid & ~bus.d_ready);
  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      region_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      region_q    <= region_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
